ram_bus_initiator: RTL and testbench
====================================

Name: ram_bus_initiator

Overview:
- Bus master for the clocked RAM bus (Addr, Data, RWn), driving the RAM responder from the initiator side.
- On a start command it write-fills a contiguous address window with a seeded pattern, reads the window back, and compares each word.
- Reports a pass/fail summary.
- Used as the built-in memory exerciser beside the RAM in top-level benches and self-test.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 8, bus data width.
- RD_LAT, 1, cycles from read address issue to valid bus_rdata. Legal range 1..4.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command pulse; accepted only when busy=0.
- base_addr  input  ADDR_W  first address of the window.
- len  input  ADDR_W  window size minus one (N = len+1 locations).
- seed  input  DATA_W  pattern seed.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse when a command completes.
- err_cnt  output  ADDR_W+1  number of mismatching reads in the last command.
- err_flag  output  1  err_cnt != 0.
- first_err_addr  output  ADDR_W  address of the first mismatch.
- bus_addr  output  ADDR_W  RAM address.
- bus_wdata  output  DATA_W  write data.
- bus_rwn  output  1  1 = read, 0 = write.
- bus_oe  output  1  initiator drives Data (write phase only).
- bus_rdata  input  DATA_W  RAM read data.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: busy=0, done=0, err_cnt=0, err_flag=0, first_err_addr=0, bus_addr=0, bus_wdata=0, bus_rwn=1, bus_oe=0, state=IDLE.
- Address i of the window is (base_addr+i) mod 2^ADDR_W, for i=0..len. Wrap past max address is legal.
- Pattern: pat(a) = a[DATA_W-1:0] ^ seed, where a is the bus address. Zero-extend a when DATA_W > ADDR_W.
- Timing reference: cycle 0 is the edge where start=1 is sampled in IDLE.
- IDLE:
  - On start, latch base_addr, len and seed.
  - Clear err_cnt, err_flag and first_err_addr.
  - Go to WRITE; busy=1 from cycle 1.
- WRITE, cycles 1..N:
  - bus_rwn=0, bus_oe=1, bus_addr=addr(i), bus_wdata=pat(addr(i)); i increments each cycle.
  - After i==len, go to TURN.
- TURN, cycle N+1:
  - bus_rwn=1, bus_oe=0, bus_addr holds.
  - This is the bus turnaround; no access is issued.
- READ, cycles N+2..2N+1:
  - Issue one read address per cycle, with bus_rwn=1 and bus_oe=0.
  - Push (addr, pat(addr)) into the check pipe.
- Check pipe:
  - bus_rdata for an address issued at cycle k is sampled at cycle k+RD_LAT.
  - On mismatch, increment err_cnt and set err_flag.
  - On the first mismatch only, load first_err_addr.
- DRAIN:
  - Wait until the last compare at cycle 2N+1+RD_LAT.
  - In cycle 2N+2+RD_LAT: done=1, busy=0, return to IDLE.
- Results (err_cnt, err_flag, first_err_addr) hold until the next accepted start.
- start while busy=1: ignored, no queueing.
- start in the same cycle as the done pulse: ignored, because the FSM is not yet in IDLE.
- rst mid-command: the next cycle shows reset values, there is no done pulse, and the command is abandoned.
- err_cnt cannot overflow: its maximum is 2^ADDR_W, which fits ADDR_W+1 bits.
- bus_oe and bus_rwn=1 are never both high.

Decomposition:
- Package ram_bus_pkg:
  - Default ADDR_W and DATA_W constants.
  - State enum typedef: IDLE, WRITE, TURN, READ, DRAIN, DONE.
  - Function pat(addr, seed).
- Sub-module ram_rd_check_pipe:
  - RD_LAT-deep shift register of {valid, addr, expected}.
  - Comparator plus err_cnt / first_err_addr update logic.
  - Cleared on rst and on accepted start.

Test Plan:
1. Reset, then base=0x00, len=0, seed=0x00, RD_LAT=1, with the behavioural RAM:
   - Write at cycle 1 (addr 0x00, data 0x00), TURN at cycle 2, read at cycle 3.
   - done at cycle 5; err_cnt=0.
2. base=0x00, len=7, seed=0xA5:
   - Writes at addresses 0..7 with data A5,A4,A7,A6,A1,A0,A3,A2.
   - busy high cycles 1..18, done at cycle 19, err_flag=0.
3. Wrap: base=0xFE, len=3, seed=0x0F:
   - Addresses FE,FF,00,01 with data F1,F0,0F,0E.
   - err_cnt=0.
4. Fault injection: RAM flips bit0 on reads of 0x03 and 0x05, with base=0, len=7:
   - err_cnt=2, first_err_addr=0x03, err_flag=1.
   - A rerun without the fault clears the results to 0.
5. start pulsed at cycle 4 (during WRITE) and again in the done cycle:
   - Both ignored; bus sequence identical to scenario 2.
6. rst asserted at cycle 12 of scenario 2:
   - Cycle 13: busy=0, bus_rwn=1, bus_oe=0, no done.
   - A new start at cycle 15 completes normally.
   - Repeat scenario 2 with RD_LAT=3: done at cycle 21.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and helpers for the RAM bus initiator and its read checker.
package ram_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DRAIN, DONE} state_e;

  // Fill pattern: address XOR seed. Callers zero-extend both operands and
  // truncate the result to DATA_W. This keeps a[DATA_W-1:0] ^ seed exact,
  // with a zero-extended address when DATA_W > ADDR_W.
  function automatic logic [63:0] pat(input logic [63:0] addr, input logic [63:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ram_rd_check_pipe.sv
// Read-back checker. It delays {valid, addr, expected} by RD_LAT cycles so the
// entry lines up with bus_rdata, then counts mismatches and keeps the first
// failing address.
module ram_rd_check_pipe #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [RD_LAT-1:0]             vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;
  logic                          mism;

  assign mism = vld_pipe[RD_LAT-1] && (rdata != exp_pipe[RD_LAT-1]);

  // Valid bits shift with reset. A new command starts with an empty pipe.
  always_ff @(posedge clk) begin
    if (rst || clr) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= in_vld;
      for (int j = 1; j < RD_LAT; j++) vld_pipe[j] <= vld_pipe[j-1];
    end
  end

  // The payload needs no reset because it is qualified by vld_pipe.
  always_ff @(posedge clk) begin
    addr_pipe[0] <= in_addr;
    exp_pipe[0]  <= in_exp;
    for (int j = 1; j < RD_LAT; j++) begin
      addr_pipe[j] <= addr_pipe[j-1];
      exp_pipe[j]  <= exp_pipe[j-1];
    end
  end

  // Accumulate mismatches. Only the first mismatch records its address.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else if (mism) begin
      err_cnt  <= err_cnt + (ADDR_W+1)'(1);
      err_flag <= 1'b1;
      if (!err_flag) first_err_addr <= addr_pipe[RD_LAT-1];
    end
  end

endmodule

// File: rtl/ram_bus_initiator.sv
// RAM bus exerciser. It write-fills a window with addr^seed, turns the bus
// around, reads the window back and counts mismatching words.
module ram_bus_initiator
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rwn,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] idx, len_q, base_q, nxt_addr;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        dcnt;       // RD_LAT is at most 4
  logic              accept, last;

  function automatic logic [DATA_W-1:0] patw(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] s);
    return DATA_W'(pat(64'(a), 64'(s)));
  endfunction

  assign accept   = (state == IDLE) && start;
  assign last     = (idx == len_q);
  assign nxt_addr = bus_addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state. DONE lasts one cycle, so a start arriving with done is dropped.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WRITE;
      WRITE:   if (last) state_n = TURN;
      TURN:    state_n = READ;
      READ:    if (last) state_n = DRAIN;
      DRAIN:   if (dcnt == 2'(RD_LAT-1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status and bus direction are registered from the next state, so they
  // change on the same edge as the state. oe is high only while rwn is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      bus_oe  <= 1'b0;
      bus_rwn <= 1'b1;
    end else begin
      busy    <= (state_n != IDLE) && (state_n != DONE);
      done    <= (state_n == DONE);
      bus_oe  <= (state_n == WRITE);
      bus_rwn <= (state_n != WRITE);
    end
  end

  // Address walk. The bus holds address i while idx == i. The address wraps
  // naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      idx       <= '0;
      base_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      dcnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q    <= base_addr;
          len_q     <= len;
          seed_q    <= seed;
          idx       <= '0;
          bus_addr  <= base_addr;
          bus_wdata <= patw(base_addr, seed);
        end
        WRITE: if (!last) begin
          idx       <= idx + ADDR_W'(1);
          bus_addr  <= nxt_addr;
          bus_wdata <= patw(nxt_addr, seed_q);
        end
        TURN: begin
          idx      <= '0;
          bus_addr <= base_q;
        end
        READ: begin
          dcnt <= '0;
          if (!last) begin
            idx      <= idx + ADDR_W'(1);
            bus_addr <= nxt_addr;
          end
        end
        DRAIN:   dcnt <= dcnt + 2'd1;
        default: ;
      endcase
    end
  end

  ram_rd_check_pipe #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .clr            (accept),
    .in_vld         (state == READ),
    .in_addr        (bus_addr),
    .in_exp         (patw(bus_addr, seed_q)),
    .rdata          (bus_rdata),
    .err_cnt        (err_cnt),
    .err_flag       (err_flag),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_ram_bus_initiator.sv
// Bench for ram_bus_initiator. Two instances (RD_LAT=1 and RD_LAT=3) share the
// stimulus. Each instance has its own behavioural RAM with optional bit0 read
// faults.
module tb_ram_bus_initiator;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] base = '0, len = '0, seed = '0;
  bit         flt_on = 1'b0;
  bit         fmask [256];

  logic       busy_a [2], done_a [2], rwn_a [2], oe_a [2], ef_a [2];
  logic [7:0] addr_a [2], wdata_a [2], fea_a [2], rdata_a [2];
  logic [8:0] ec_a [2];

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] mem [256];
    logic [7:0] rq [L];

    ram_bus_initiator #(.ADDR_W(8), .DATA_W(8), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base), .len(len), .seed(seed),
      .busy(busy_a[g]), .done(done_a[g]), .err_cnt(ec_a[g]), .err_flag(ef_a[g]),
      .first_err_addr(fea_a[g]), .bus_addr(addr_a[g]), .bus_wdata(wdata_a[g]),
      .bus_rwn(rwn_a[g]), .bus_oe(oe_a[g]), .bus_rdata(rdata_a[g])
    );

    // RAM: address sampled at the edge, data out L edges later.
    always @(posedge clk) begin
      if (!rwn_a[g] && oe_a[g]) mem[addr_a[g]] <= wdata_a[g];
      rq[0] <= mem[addr_a[g]] ^ {7'd0, (flt_on && fmask[addr_a[g]])};
      for (int j = 1; j < L; j++) rq[j] <= rq[j-1];
    end
    assign rdata_a[g] = rq[L-1];
  end

  task automatic chk(input string nm, input int d, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, c, got, exp);
    end
  endtask

  task automatic chk_reset(input int c);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, c, busy_a[d], 0);
      chk("rst_done", d, c, done_a[d], 0);
      chk("rst_errcnt", d, c, ec_a[d], 0);
      chk("rst_errflag", d, c, ef_a[d], 0);
      chk("rst_firsterr", d, c, fea_a[d], 0);
      chk("rst_addr", d, c, addr_a[d], 0);
      chk("rst_wdata", d, c, wdata_a[d], 0);
      chk("rst_rwn", d, c, rwn_a[d], 1);
      chk("rst_oe", d, c, oe_a[d], 0);
    end
  endtask

  // Reference model for the error summary: walk the window and count the
  // addresses the RAM corrupts.
  function automatic void model_err(input logic [7:0] b, input logic [7:0] l,
                                    output int ne, output int fa);
    int a;
    ne = 0; fa = 0;
    for (int i = 0; i <= int'(l); i++) begin
      a = (int'(b) + i) % 256;
      if (flt_on && fmask[a]) begin
        if (ne == 0) fa = a;
        ne++;
      end
    end
  endfunction

  // Issue one command and check every cycle against the timeline derived from
  // N = len+1:
  //   writes in cycles 1..N, turnaround in N+1, reads in N+2..2N+1,
  //   done in 2N+2+L.
  // On entry and exit the task sits just after a negedge.
  task automatic run_cmd(input logic [7:0] b, input logic [7:0] l, input logic [7:0] s,
                         input bit f, input int ee, input int efa,
                         input int stray_at, input bit stray_done, input int rst_at);
    int n, dc, ea;
    n = int'(l) + 1;
    base = b; len = l; seed = s; flt_on = f; start = 1'b1;
    @(posedge clk);                       // cycle 0 edge
    for (int c = 1; c <= 2*n + 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst = 1'b0;
        chk_reset(c);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          chk("post_rst_done", d, c+1, done_a[d], 0);
          chk("post_rst_busy", d, c+1, busy_a[d], 0);
        end
        break;
      end
      for (int d = 0; d < 2; d++) begin
        dc = 2*n + 2 + ((d == 0) ? 1 : 3);
        chk("busy", d, c, busy_a[d], int'(c < dc));
        chk("done", d, c, done_a[d], int'(c == dc));
        if (c <= n) begin
          ea = (int'(b) + c - 1) % 256;
          chk("wr_oe", d, c, oe_a[d], 1);
          chk("wr_rwn", d, c, rwn_a[d], 0);
          chk("wr_addr", d, c, addr_a[d], ea);
          chk("wr_data", d, c, wdata_a[d], ea ^ int'(s));
        end else begin
          chk("rd_oe", d, c, oe_a[d], 0);
          chk("rd_rwn", d, c, rwn_a[d], 1);
          if (c == n + 1)
            chk("turn_addr", d, c, addr_a[d], (int'(b) + n - 1) % 256);
          else if (c <= 2*n + 1)
            chk("rd_addr", d, c, addr_a[d], (int'(b) + c - n - 2) % 256);
        end
        if (c >= dc) begin
          chk("err_cnt", d, c, ec_a[d], ee);
          chk("err_flag", d, c, ef_a[d], int'(ee != 0));
          chk("first_err", d, c, fea_a[d], efa);
        end
      end
      if (c == stray_at || (stray_done && c == 2*n + 3)) start = 1'b1;
      if (c == rst_at) rst = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] b, l, s;
    bit         f;
    int         ee, efa;
    int         stray;
    bit         sdone;
    int         rst_at;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ne, fa;
    logic [7:0] rb, rl, rs;
    bit rf;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 0, 0,    -1, 1'b0, -1};  // single word
    tbl[1] = '{8'h00, 8'h07, 8'hA5, 1'b0, 0, 0,    -1, 1'b0, -1};  // 8 words
    tbl[2] = '{8'hFE, 8'h03, 8'h0F, 1'b0, 0, 0,    -1, 1'b0, -1};  // wrap
    tbl[3] = '{8'h00, 8'h07, 8'hA5, 1'b1, 2, 8'h03, -1, 1'b0, -1}; // faults 03,05
    tbl[4] = '{8'h00, 8'h07, 8'hA5, 1'b0, 0, 0,    -1, 1'b0, -1};  // clean rerun
    tbl[5] = '{8'h00, 8'h07, 8'hA5, 1'b0, 0, 0,     4, 1'b1, -1};  // stray starts
    tbl[6] = '{8'h00, 8'h07, 8'hA5, 1'b0, 0, 0,    -1, 1'b0, 12};  // reset mid-run
    tbl[7] = '{8'h00, 8'h07, 8'hA5, 1'b0, 0, 0,    -1, 1'b0, -1};  // restart after rst

    for (int a = 0; a < 256; a++) fmask[a] = 1'b0;
    fmask[3] = 1'b1;
    fmask[5] = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      run_cmd(tbl[t].b, tbl[t].l, tbl[t].s, tbl[t].f, tbl[t].ee, tbl[t].efa,
              tbl[t].stray, tbl[t].sdone, tbl[t].rst_at);
      @(negedge clk);
    end

    // Randomized commands, with random fault maps scored by model_err.
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      rl = (k == 0) ? 8'hFF : 8'($urandom_range(0, 40));
      rs = 8'($urandom);
      rf = 1'($urandom_range(0, 1));
      for (int a = 0; a < 256; a++) fmask[a] = ($urandom_range(0, 7) == 0);
      flt_on = rf;
      model_err(rb, rl, ne, fa);
      run_cmd(rb, rl, rs, rf, ne, fa, -1, 1'b0, -1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
